// File: rtl/axis_crc_pkg.sv
// axis_crc_pkg: shared types and CRC helper functions for the AXI-Stream CRC engine.
//   crc_mode_e    : GEN (append CRC) / CHK (verify trailing CRC by residue)
//   crc_state_e   : engine FSM states
//   crc_byte_step : one byte through an up-to-32-bit serial CRC, normal-form polynomial
//   bit_reverse   : reverse the low 'width' bits of a 32-bit word
package axis_crc_pkg;

  typedef enum logic {
    CRC_GEN = 1'b0,
    CRC_CHK = 1'b1
  } crc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_APPEND = 2'd2
  } crc_state_e;

  // The register is left-aligned in 32 bits so the feedback tap is always bit 31,
  // whatever the CRC width; the result is shifted back down at the end.
  function automatic logic [31:0] crc_byte_step(input logic [31:0]   crc,
                                                input logic [7:0]    data,
                                                input logic [31:0]   poly,
                                                input int unsigned   width,
                                                input logic          refin);
    logic [31:0] c;
    logic [31:0] p;
    logic [7:0]  d;
    logic        fb;
    c = crc << (32 - width);
    p = poly << (32 - width);
    for (int i = 0; i < 8; i++) begin
      d[i] = refin ? data[7-i] : data[i];
    end
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[7-i];
      c  = c << 1;
      if (fb) c = c ^ p;
    end
    return c >> (32 - width);
  endfunction

  // Caller must pass v with bits above 'width' cleared.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v,
                                              input int unsigned width);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = v[i];
    end
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/axis_crc_engine_crc_byte_update.sv
// crc_byte_update: purely combinational next-CRC for one input byte.
//   crc_in  [CRC_W-1:0] : current CRC register
//   data_in [7:0]       : byte to absorb (LSB-first when REFIN=1)
//   crc_out [CRC_W-1:0] : register after 8 serial polynomial steps
module crc_byte_update
  import axis_crc_pkg::*;
#(
  parameter int unsigned      CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h07),
  parameter bit               REFIN = 1'b0
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data_in,
  output logic [CRC_W-1:0] crc_out
);

  assign crc_out = CRC_W'(crc_byte_step(32'(crc_in), data_in, 32'(POLY), CRC_W, REFIN));

endmodule

// File: rtl/axis_crc_engine.sv
// axis_crc_engine: byte-wide AXI-Stream CRC generator / checker with one output register.
//   aclk, areset          : clock, asynchronous active-high reset
//   s_axis_*              : input byte stream (tdata/tvalid/tlast/tready)
//   m_axis_*              : output byte stream; tuser flags a CRC error on the CHK last beat
//   crc_en                : packet CRC enable, sampled on the first beat of each packet
//   crc_value, crc_done   : final CRC of the last completed packet and its update pulse
//   pkt_count, err_count  : present only when CRC_AXIS_STATS_EN is defined
//
// state     | meaning
// ST_IDLE   | waiting for the first beat of a packet; crc register base is INIT
// ST_DATA   | mid-packet, each accepted byte updates the crc register
// ST_APPEND | GEN only: emitting the CRC_W/8 final CRC bytes, input stalled
module axis_crc_engine
  import axis_crc_pkg::*;
#(
  parameter int unsigned      CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOROUT  = '0,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0,
  parameter bit               MODE    = 1'b0,
  parameter logic [CRC_W-1:0] RESIDUE = '0
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  input  logic             crc_en,
  output logic [CRC_W-1:0] crc_value,
  output logic             crc_done
`ifdef CRC_AXIS_STATS_EN
  ,
  output logic [31:0]      pkt_count,
  output logic [31:0]      err_count
`endif
);

  localparam int unsigned NBYTES = CRC_W / 8;
  localparam crc_mode_e   MODE_E = crc_mode_e'(MODE);
  localparam bit          IS_CHK = (MODE_E == CRC_CHK);

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] app_sr_q, app_sr_d;
  logic [CRC_W-1:0] crc_value_q, crc_value_d;
  logic             crc_done_q, crc_done_d;
  logic             pkt_en_q, pkt_en_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;

  logic [CRC_W-1:0] crc_base, crc_next, crc_final;
  logic             pkt_en_cur, out_ready, s_ready, in_xfer;

  assign out_ready  = !m_valid_q || m_axis_tready;
  assign s_ready    = out_ready && (state_q != ST_APPEND) && !areset;
  assign in_xfer    = s_axis_tvalid && s_ready;
  // First beat of a packet starts from INIT and uses the live crc_en.
  assign crc_base   = (state_q == ST_IDLE) ? INIT : crc_q;
  assign pkt_en_cur = (state_q == ST_IDLE) ? crc_en : pkt_en_q;

  crc_byte_update #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .REFIN (REFIN)
  ) u_byte_update (
    .crc_in  (crc_base),
    .data_in (s_axis_tdata),
    .crc_out (crc_next)
  );

  assign crc_final = (REFOUT ? CRC_W'(bit_reverse(32'(crc_next), CRC_W)) : crc_next) ^ XOROUT;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    app_sr_d    = app_sr_q;
    crc_value_d = crc_value_q;
    crc_done_d  = 1'b0;
    pkt_en_d    = pkt_en_q;
    cnt_d       = cnt_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_axis_tready;
    m_last_d    = m_last_q;
    m_user_d    = m_user_q;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (in_xfer) begin
          crc_d     = crc_next;
          pkt_en_d  = pkt_en_cur;
          m_data_d  = s_axis_tdata;
          m_valid_d = 1'b1;
          m_last_d  = s_axis_tlast;
          m_user_d  = 1'b0;
          state_d   = ST_DATA;
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
            if (pkt_en_cur) begin
              crc_value_d = crc_final;
              crc_done_d  = 1'b1;
              if (IS_CHK) begin
                m_user_d = (crc_next != RESIDUE);
              end else begin
                // Packet continues with the CRC bytes, so this beat is not last.
                m_last_d = 1'b0;
                app_sr_d = crc_final;
                cnt_d    = 3'(NBYTES);
                state_d  = ST_APPEND;
              end
            end
          end
        end
      end
      ST_APPEND: begin
        if (out_ready) begin
          m_valid_d = 1'b1;
          m_user_d  = 1'b0;
          m_data_d  = REFOUT ? app_sr_q[7:0] : app_sr_q[CRC_W-1 -: 8];
          app_sr_d  = REFOUT ? (app_sr_q >> 8) : (app_sr_q << 8);
          cnt_d     = cnt_q - 3'd1;
          m_last_d  = (cnt_q == 3'd1);
          if (cnt_q == 3'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      app_sr_q    <= '0;
      crc_value_q <= '0;
      crc_done_q  <= 1'b0;
      pkt_en_q    <= 1'b0;
      cnt_q       <= 3'd0;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      app_sr_q    <= app_sr_d;
      crc_value_q <= crc_value_d;
      crc_done_q  <= crc_done_d;
      pkt_en_q    <= pkt_en_d;
      cnt_q       <= cnt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign crc_value     = crc_value_q;
  assign crc_done      = crc_done_q;

`ifdef CRC_AXIS_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (crc_done_d && (pkt_cnt_q != 32'hFFFF_FFFF)) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (crc_done_d && IS_CHK && m_user_d && (err_cnt_q != 32'hFFFF_FFFF))
      err_cnt_d = err_cnt_q + 32'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt_q <= 32'd0;
      err_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule
